// File: rtl/sd_spi_master.sv
// sd_spi_master: byte-wide SPI mode-0 (MSB first) master for SD cards, controlled
// through a four-register bus (DATA, STATUS, CTRL, DIV). DIV is latched at transfer start.
module sd_spi_master #(
  parameter logic [7:0] DEFAULT_DIV = 8'd24,
  parameter logic       MOSI_IDLE   = 1'b1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       cs,
  input  logic       we,
  input  logic [1:0] addr,
  input  logic [7:0] data_i,
  output logic [7:0] data_o,
  output logic       sd_cs,
  output logic       spi_clk,
  output logic       spi_mosi,
  input  logic       spi_miso,
  output logic       irq,
  output logic [1:0] o_dbg_state
);

  typedef enum logic [1:0] {S_IDLE, S_LOW, S_HIGH, S_DONE} state_t;

  localparam logic [1:0] A_DATA = 2'd0;
  localparam logic [1:0] A_STAT = 2'd1;
  localparam logic [1:0] A_CTRL = 2'd2;
  localparam logic [1:0] A_DIV  = 2'd3;

  // Bus handshake: every clk edge with cs high is one access, no wait states.
  // we=1 writes data_i into register addr; we=0 reads, data_o tracks addr combinationally.
  state_t     r_state;
  logic [7:0] r_div;
  logic [7:0] r_div_lat;
  logic [7:0] r_cnt;
  logic [7:0] r_tx;
  logic [7:0] r_rx_sh;
  logic [7:0] r_rx;
  logic [2:0] r_bit;
  logic       r_busy;
  logic       r_done;
  logic       r_irq_en;
  logic       r_sd_cs;
  logic       r_spi_clk;
  logic       r_mosi;

  logic w_data_wr;
  logic w_data_rd;
  logic w_cnt_zero;

  assign w_data_wr  = cs & we & (addr == A_DATA);
  assign w_data_rd  = cs & ~we & (addr == A_DATA);
  assign w_cnt_zero = (r_cnt == 8'd0);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= S_IDLE;
      r_div     <= DEFAULT_DIV;
      r_div_lat <= DEFAULT_DIV;
      r_cnt     <= 8'd0;
      r_tx      <= 8'h00;
      r_rx_sh   <= 8'h00;
      r_rx      <= 8'h00;
      r_bit     <= 3'd0;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
      r_irq_en  <= 1'b0;
      r_sd_cs   <= 1'b1;
      r_spi_clk <= 1'b0;
      r_mosi    <= MOSI_IDLE;
    end else begin
      if (cs && we && addr == A_CTRL) begin
        r_sd_cs  <= data_i[0];
        r_irq_en <= data_i[1];
      end
      if (cs && we && addr == A_DIV) r_div <= data_i;
      // A read clears done; the DONE-state set below is assigned later and wins.
      if (w_data_rd) r_done <= 1'b0;

      case (r_state)
        S_IDLE: begin
          if (w_data_wr) begin
            r_state   <= S_LOW;
            r_tx      <= data_i;
            r_mosi    <= data_i[7];
            r_busy    <= 1'b1;
            r_done    <= 1'b0;
            r_cnt     <= r_div;
            r_div_lat <= r_div;
            r_bit     <= 3'd0;
          end
        end
        S_LOW: begin
          if (w_cnt_zero) begin
            r_state   <= S_HIGH;
            r_spi_clk <= 1'b1;
            r_rx_sh   <= {r_rx_sh[6:0], spi_miso};
            r_cnt     <= r_div_lat;
          end else begin
            r_cnt <= r_cnt - 8'd1;
          end
        end
        S_HIGH: begin
          if (w_cnt_zero) begin
            r_spi_clk <= 1'b0;
            if (r_bit == 3'd7) begin
              r_state <= S_DONE;
            end else begin
              r_state <= S_LOW;
              r_tx    <= {r_tx[6:0], 1'b0};
              r_mosi  <= r_tx[6];
              r_bit   <= r_bit + 3'd1;
              r_cnt   <= r_div_lat;
            end
          end else begin
            r_cnt <= r_cnt - 8'd1;
          end
        end
        S_DONE: begin
          r_rx    <= r_rx_sh;
          r_done  <= 1'b1;
          r_busy  <= 1'b0;
          r_mosi  <= MOSI_IDLE;
          r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  always_comb begin
    data_o = 8'h00;
    case (addr)
      A_DATA:  data_o = r_rx;
      A_STAT:  data_o = {r_done, r_busy, 6'b0};
      A_CTRL:  data_o = {6'b0, r_irq_en, r_sd_cs};
      A_DIV:   data_o = r_div;
      default: data_o = 8'h00;
    endcase
  end

  assign sd_cs       = r_sd_cs;
  assign spi_clk     = r_spi_clk;
  assign spi_mosi    = r_mosi;
  assign irq         = r_done & r_irq_en;
  assign o_dbg_state = r_state;

endmodule

// File: tb/tb_sd_spi_master.sv
// Bench for sd_spi_master: cycle model of SCK/MOSI/sd_cs/irq plus a loopback / SD-card
// emulator on the serial side, with directed register-level scenarios.
module tb_sd_spi_master;

  logic       clk;
  logic       rst;
  logic       cs;
  logic       we;
  logic [1:0] addr;
  logic [7:0] data_i;
  logic [7:0] data_o;
  logic       sd_cs;
  logic       spi_clk;
  logic       spi_mosi;
  logic       spi_miso;
  logic       irq;
  logic [1:0] dbg_state;

  int n_checks = 0;
  int n_err    = 0;

  sd_spi_master dut (
    .clk(clk), .rst(rst), .cs(cs), .we(we), .addr(addr), .data_i(data_i),
    .data_o(data_o), .sd_cs(sd_cs), .spi_clk(spi_clk), .spi_mosi(spi_mosi),
    .spi_miso(spi_miso), .irq(irq), .o_dbg_state(dbg_state)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // ---------------- behavioural model ----------------
  // A transfer is 16 half-periods of (d+1) clocks followed by one DONE clock.
  bit         m_valid = 0;
  bit         m_busy, m_done, m_sd_cs, m_irq_en;
  int         m_t, m_d;
  logic [7:0] m_div, m_tx;

  always @(posedge clk) begin
    if (rst) begin
      m_valid  = 1;
      m_busy   = 0;
      m_done   = 0;
      m_sd_cs  = 1;
      m_irq_en = 0;
      m_div    = 8'd24;
    end else if (m_valid) begin
      bit set_done;
      set_done = 0;
      if (m_busy) begin
        m_t++;
        if (m_t == 16 * (m_d + 1) + 1) begin
          m_busy   = 0;
          set_done = 1;
        end
      end else if (cs && we && addr == 2'd0) begin
        m_busy = 1;
        m_t    = 0;
        m_d    = int'(m_div);
        m_tx   = data_i;
        m_done = 0;
      end
      if (set_done) m_done = 1;
      else if (cs && !we && addr == 2'd0) m_done = 0;
      if (cs && we && addr == 2'd2) begin
        m_sd_cs  = data_i[0];
        m_irq_en = data_i[1];
      end
      if (cs && we && addr == 2'd3) m_div = data_i;
    end
  end

  // Per-cycle compare of the serial pins and irq against the model.
  always @(negedge clk) begin
    int   idx;
    logic e_sck, e_mosi;
    if (m_valid) begin
      e_sck  = m_busy && (((m_t / (m_d + 1)) % 2) == 1);
      idx    = m_t / (2 * (m_d + 1));
      if (idx > 7) idx = 7;
      e_mosi = m_busy ? m_tx[7 - idx] : 1'b1;
      check("cyc_spi_clk", spi_clk, e_sck);
      check("cyc_spi_mosi", spi_mosi, e_mosi);
      check("cyc_sd_cs", sd_cs, m_sd_cs);
      check("cyc_irq", irq, m_done & m_irq_en);
    end
  end

  // ---------------- serial-side emulator ----------------
  logic [7:0] emu_sr = 8'hFF;
  logic [7:0] emu_rx = 8'h00;
  logic [7:0] emu_last_rx = 8'h00;
  logic [7:0] loop_byte = 8'hFF;
  int         emu_bits = 0;
  int         emu_rises = 0;
  int         sck_edges = 0;
  bit         emu_sd_mode = 0;
  logic [7:0] emu_cmd[$];
  logic [7:0] emu_out_q[$];
  logic [7:0] cmd0 [0:5];

  assign spi_miso = emu_sr[7];

  always @(spi_clk) sck_edges++;

  always @(posedge spi_clk) begin
    emu_rx = {emu_rx[6:0], spi_mosi};
    emu_bits++;
    emu_rises++;
  end

  always @(negedge spi_clk) begin
    bit m;
    if (emu_bits == 8) begin
      emu_bits    = 0;
      emu_last_rx = emu_rx;
      if (emu_sd_mode && !sd_cs) begin
        emu_cmd.push_back(emu_rx);
        if (emu_cmd.size() > 6) void'(emu_cmd.pop_front());
        if (emu_cmd.size() == 6) begin
          m = 1;
          for (int i = 0; i < 6; i++) if (emu_cmd[i] !== cmd0[i]) m = 0;
          if (m) begin
            emu_out_q.push_back(8'hFF);
            emu_out_q.push_back(8'h01);
            emu_cmd.delete();
          end
        end
      end
      if (emu_out_q.size() > 0) emu_sr = emu_out_q.pop_front();
      else emu_sr = emu_sd_mode ? 8'hFF : loop_byte;
    end else begin
      emu_sr = {emu_sr[6:0], 1'b1};
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic reg_write(input logic [1:0] a, input logic [7:0] d);
    cs = 1'b1; we = 1'b1; addr = a; data_i = d;
    tick();
    cs = 1'b0; we = 1'b0; addr = 2'd1;
  endtask

  task automatic reg_read(input logic [1:0] a, output logic [7:0] d);
    cs = 1'b1; we = 1'b0; addr = a;
    @(negedge clk);
    d = data_o;
    tick();
    cs = 1'b0; addr = 2'd1;
  endtask

  task automatic preload(input logic [7:0] b);
    emu_sr    = b;
    loop_byte = b;
    emu_bits  = 0;
    emu_rises = 0;
  endtask

  // Counts negedges with STATUS.busy high after a start; returns irq at the first idle one.
  task automatic wait_busy(input string tag, output int n, output logic irq_fall);
    bit fin;
    n = 0; irq_fall = 1'b0; fin = 0; addr = 2'd1;
    while (!fin) begin
      @(negedge clk);
      if (data_o[6] !== 1'b1) begin
        irq_fall = irq;
        fin = 1;
      end else begin
        n++;
        if (n > 5000) begin
          check({tag, "_timeout"}, 32'd0, 32'd1);
          fin = 1;
        end
      end
    end
    tick();
  endtask

  // ---------------- scenarios ----------------
  initial begin
    logic [7:0] rd;
    int         n;
    logic       irqf;
    int         g;
    int         polls;
    bit         found;

    cmd0[0] = 8'h40; cmd0[1] = 8'h00; cmd0[2] = 8'h00;
    cmd0[3] = 8'h00; cmd0[4] = 8'h00; cmd0[5] = 8'h95;
    rst = 1'b1; cs = 1'b0; we = 1'b0; addr = 2'd1; data_i = 8'h00;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    // Reset values of the register map.
    reg_read(2'd0, rd); check("rst_data", rd, 8'h00);
    reg_read(2'd1, rd); check("rst_status", rd, 8'h00);
    reg_read(2'd2, rd); check("rst_ctrl", rd, 8'h01);
    reg_read(2'd3, rd); check("rst_div", rd, 8'd24);
    check("rst_dbg_idle", dbg_state, 2'd0);

    // DIV=0, A5 out, 3C back.
    reg_write(2'd3, 8'h00);
    preload(8'h3C);
    reg_write(2'd0, 8'hA5);
    wait_busy("div0", n, irqf);
    check("div0_busy_cycles", n, 17);
    check("div0_sck_rises", emu_rises, 8);
    check("div0_mosi_byte", emu_last_rx, 8'hA5);
    reg_read(2'd1, rd); check("div0_status_done", rd, 8'h80);
    reg_read(2'd0, rd); check("div0_rx", rd, 8'h3C);
    reg_read(2'd1, rd); check("div0_status_clr", rd, 8'h00);

    // DIV=3, FF out; a second DATA write and a DIV write land mid-transfer.
    reg_write(2'd3, 8'd3);
    preload(8'h81);
    reg_write(2'd0, 8'hFF);
    repeat (10) tick();
    reg_write(2'd0, 8'h00);
    reg_write(2'd3, 8'd1);
    wait_busy("div3", n, irqf);
    check("div3_busy_cycles", n + 12, 65);
    check("div3_mosi_byte", emu_last_rx, 8'hFF);
    check("div3_sck_rises", emu_rises, 8);
    reg_read(2'd0, rd); check("div3_rx", rd, 8'h81);
    reg_read(2'd3, rd); check("div3_div_new", rd, 8'd1);

    // irq enabled (CTRL=02 also drives sd_cs low), DIV=1 now applies.
    reg_write(2'd2, 8'h02);
    reg_read(2'd2, rd); check("ctrl_readback", rd, 8'h02);
    preload(8'h5A);
    reg_write(2'd0, 8'hC3);
    wait_busy("irq", n, irqf);
    check("irq_busy_cycles", n, 33);
    check("irq_at_done_plus1", irqf, 1'b1);
    check("irq_mosi_byte", emu_last_rx, 8'hC3);
    tick();
    check("irq_held", irq, 1'b1);
    reg_read(2'd0, rd); check("irq_rx", rd, 8'h5A);
    @(negedge clk);
    check("irq_after_read", irq, 1'b0);
    tick();

    // Reset in the middle of a transfer.
    reg_write(2'd2, 8'h00);
    preload(8'h3C);
    sck_edges = 0;
    reg_write(2'd0, 8'h77);
    g = 0;
    while (sck_edges < 4 && g < 200) begin tick(); g++; end
    check("rst_mid_reached_edge4", sck_edges >= 4, 1'b1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    addr = 2'd1;
    @(negedge clk);
    check("rst_mid_sck", spi_clk, 1'b0);
    check("rst_mid_sd_cs", sd_cs, 1'b1);
    check("rst_mid_busy", data_o[6], 1'b0);
    check("rst_mid_irq", irq, 1'b0);
    tick();
    repeat (5) tick();
    reg_read(2'd0, rd); check("rst_mid_rx", rd, 8'h00);
    reg_read(2'd1, rd); check("rst_mid_status", rd, 8'h00);
    preload(8'h96);
    reg_write(2'd0, 8'h11);
    wait_busy("post_rst", n, irqf);
    check("post_rst_busy_cycles", n, 401);
    check("post_rst_mosi_byte", emu_last_rx, 8'h11);
    reg_read(2'd1, rd); check("post_rst_status", rd, 8'h80);
    reg_read(2'd0, rd); check("post_rst_rx", rd, 8'h96);

    // Slowest divider.
    reg_write(2'd3, 8'd255);
    preload(8'h0F);
    reg_write(2'd0, 8'hF0);
    wait_busy("div255", n, irqf);
    check("div255_busy_cycles", n, 4097);
    check("div255_mosi_byte", emu_last_rx, 8'hF0);
    reg_read(2'd0, rd); check("div255_rx", rd, 8'h0F);
    reg_read(2'd3, rd); check("div255_div", rd, 8'd255);

    // SD card: CMD0 with sd_cs low, then poll with FF for R1.
    reg_write(2'd3, 8'd1);
    reg_write(2'd2, 8'h00);
    emu_sd_mode = 1;
    emu_cmd.delete();
    emu_out_q.delete();
    preload(8'hFF);
    for (int i = 0; i < 6; i++) begin
      reg_write(2'd0, cmd0[i]);
      wait_busy("cmd0_byte", n, irqf);
      check("cmd0_byte_sent", emu_last_rx, cmd0[i]);
    end
    polls = 0;
    found = 0;
    rd = 8'hFF;
    while (!found && polls < 8) begin
      reg_write(2'd0, 8'hFF);
      wait_busy("poll", n, irqf);
      reg_read(2'd0, rd);
      polls++;
      if (rd != 8'hFF) found = 1;
    end
    check("cmd0_r1", rd, 8'h01);
    check("cmd0_polls", polls, 2);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
